// File: rtl/codec_ctrl_pkg.sv
// Shared definitions for the codec control port: register map, defaults, field positions.
package codec_ctrl_pkg;

    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DATA_W   = 9;
    localparam int unsigned WORD_W   = ADDR_W + DATA_W;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned DEF_REGS = 10;

    // Register addresses
    localparam logic [ADDR_W-1:0] LINVOL = 7'h00;
    localparam logic [ADDR_W-1:0] RINVOL = 7'h01;
    localparam logic [ADDR_W-1:0] LHPVOL = 7'h02;
    localparam logic [ADDR_W-1:0] RHPVOL = 7'h03;
    localparam logic [ADDR_W-1:0] APATH  = 7'h04;
    localparam logic [ADDR_W-1:0] DPATH  = 7'h05;
    localparam logic [ADDR_W-1:0] PWRDN  = 7'h06;
    localparam logic [ADDR_W-1:0] IFACE  = 7'h07;
    localparam logic [ADDR_W-1:0] SRATE  = 7'h08;
    localparam logic [ADDR_W-1:0] ACTIVE = 7'h09;
    localparam logic [ADDR_W-1:0] RESET  = 7'h0F;

    // Field bit positions shared with the configurator
    localparam int unsigned VOL_LRBOTH_BIT     = 8;
    localparam int unsigned INVOL_MUTE_BIT     = 7;
    localparam int unsigned APATH_DACSEL_BIT   = 4;
    localparam int unsigned DPATH_ADCHPD_BIT   = 0;
    localparam int unsigned PWRDN_POWEROFF_BIT = 7;
    localparam int unsigned IFACE_MS_BIT       = 6;
    localparam int unsigned SRATE_USB_BIT      = 0;
    localparam int unsigned ACTIVE_BIT         = 0;

    // One serial control word as it sits in the shifter
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ctrl_word_t;

    // Power-on / software-reset default table
    function automatic logic [DATA_W-1:0] reg_default(input int unsigned idx);
        case (idx)
            0:       return 9'h097;
            1:       return 9'h097;
            2:       return 9'h079;
            3:       return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            8:       return 9'h000;
            9:       return 9'h000;
            default: return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// N-stage synchroniser with registered rising-edge pulse; level output is aligned with the pulse.
module spi_in_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    // Synchroniser chain, previous-cycle copy and edge pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;

endmodule

// File: rtl/codec_ctrl_responder.sv
// SPI slave emulating the codec's 16-bit register write port with a 9-bit register file.
module codec_ctrl_responder
    import codec_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESET_ADDR  = 15
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    spi_sck,
    input  logic                    spi_mosi,
    input  logic                    spi_cs,
    output logic [9*NUM_REGS-1:0]   reg_flat,
    output logic                    wr_stb,
    output logic [6:0]              wr_addr,
    output logic [8:0]              wr_data,
    output logic                    active,
    output logic                    sw_reset,
    output logic                    frame_err,
    output logic                    bad_addr
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                w_sck_rise;
    logic                w_sck_level_unused;
    logic                w_mosi;
    logic                w_mosi_rise_unused;
    logic                w_cs_rise;
    logic                w_cs_level_unused;

    logic [WORD_W-1:0]   r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic [WORD_W-1:0]   w_shift_next;
    logic [CNT_W-1:0]    w_cnt_next;
    ctrl_word_t          w_word;
    logic                w_short;
    logic                w_is_rst;
    logic                w_in_range;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .resetn(resetn), .i_d(spi_sck),
        .o_level(w_sck_level_unused), .o_rise(w_sck_rise)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetn(resetn), .i_d(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused)
    );

    // CS idles high, so its chain resets high to avoid a false latch edge at release
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .resetn(resetn), .i_d(spi_cs),
        .o_level(w_cs_level_unused), .o_rise(w_cs_rise)
    );

    // Shift and count first, so a same-cycle CS rise commits the fresh bit
    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        if (w_sck_rise) begin
            w_shift_next = {r_shift[WORD_W-2:0], w_mosi};
            if (r_cnt != 5'd31) begin
                w_cnt_next = r_cnt + 5'd1;
            end
        end
        w_word     = w_shift_next;
        w_short    = (w_cnt_next < 5'd16);
        w_is_rst   = (w_word.addr == ADDR_W'(RESET_ADDR));
        w_in_range = (32'(w_word.addr) < NUM_REGS);
    end

    // Shifter, bit counter, word decode and register file
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            wr_stb    <= 1'b0;
            sw_reset  <= 1'b0;
            frame_err <= 1'b0;
            bad_addr  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[IDX_W'(i)] <= reg_default(i);
            end
        end else begin
            wr_stb    <= 1'b0;
            sw_reset  <= 1'b0;
            frame_err <= 1'b0;
            bad_addr  <= 1'b0;
            r_shift   <= w_shift_next;
            r_cnt     <= w_cnt_next;
            if (w_cs_rise) begin
                r_cnt   <= '0;
                wr_addr <= w_word.addr;
                wr_data <= w_word.data;
                if (w_short) begin
                    frame_err <= 1'b1;
                end else if (w_is_rst) begin
                    wr_stb   <= 1'b1;
                    sw_reset <= 1'b1;
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        r_regs[IDX_W'(i)] <= reg_default(i);
                    end
                end else if (w_in_range) begin
                    wr_stb <= 1'b1;
                    r_regs[IDX_W'(w_word.addr)] <= w_word.data;
                end else begin
                    bad_addr <= 1'b1;
                end
            end
        end
    end

    // Flatten the register file onto the output bus
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign reg_flat[9*g +: 9] = r_regs[g];
    end

    assign active = r_regs[IDX_W'(ACTIVE)][ACTIVE_BIT];

endmodule
